// File: rtl/sha1_msg_padder.sv
// SHA-1 message padder: buffers a 32-bit big-endian word stream into 16-word blocks,
// appends marker/zero-fill/bit-length, and sequences the compression core per block.
module sha1_msg_padder #(
  parameter logic [159:0] IV = 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  in_data,
  input  logic [2:0]   in_nbytes,
  input  logic         in_last,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [31:0]  din,
  output logic         load,
  output logic         start,
  output logic         use_prev_cv,
  output logic [159:0] cv,
  input  logic         core_busy,
  input  logic [159:0] core_cv_next,
  output logic [159:0] digest,
  output logic         digest_valid
);
  typedef enum logic [2:0] {FILL, PAD, BURST, START, GUARD, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] mbuf [16];
  logic [3:0]  widx;
  logic [60:0] byte_cnt;
  logic        first_blk, marker_done, len_wr, final_blk, tail;
  logic        take;
  logic [2:0]  nb;
  logic [63:0] bit_len;
  logic [31:0] tail_word, pad_word, din_d;
  logic        load_d, start_d, upc_d;

  assign cv       = IV;
  assign in_ready = (state == FILL) && !reset;
  assign take     = in_valid && in_ready;
  assign bit_len  = {byte_cnt, 3'b000};
  assign nb       = !in_last ? 3'd4 : (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;

  // Final word: keep n data bytes, marker in byte n, zeros below.
  always_comb begin
    case (in_nbytes)
      3'd0:    tail_word = 32'h8000_0000;
      3'd1:    tail_word = {in_data[31:24], 24'h80_0000};
      3'd2:    tail_word = {in_data[31:16], 16'h8000};
      3'd3:    tail_word = {in_data[31:8], 8'h80};
      default: tail_word = in_data;
    endcase
  end

  // len_wr records at index 14 whether the marker already fit, i.e. this block carries the length.
  always_comb begin
    pad_word = 32'h0;
    if (!marker_done)                  pad_word = 32'h8000_0000;
    else if (widx == 4'd14)            pad_word = bit_len[63:32];
    else if (widx == 4'd15 && len_wr)  pad_word = bit_len[31:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:  if (take) begin
               if (widx == 4'd15)  state_nxt = BURST;
               else if (in_last)   state_nxt = PAD;
             end
      PAD:   if (widx == 4'd15) state_nxt = BURST;
      BURST: if (widx == 4'd15) state_nxt = START;
      START: state_nxt = GUARD;
      GUARD: state_nxt = WAIT;
      WAIT:  if (!core_busy) state_nxt = final_blk ? DONE : (tail ? PAD : FILL);
      DONE:  state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    load_d  = 1'b0;
    start_d = 1'b0;
    upc_d   = 1'b0;
    din_d   = din;
    case (state)
      BURST: begin load_d = 1'b1; din_d = mbuf[widx]; end
      START: begin start_d = 1'b1; upc_d = !first_blk; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == PAD) mbuf[widx] <= pad_word;
    else if (take)    mbuf[widx] <= in_last ? tail_word : in_data;
  end

  // widx wraps to 0 at the end of every fill/pad/burst pass, so each phase starts aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      widx        <= '0;
      byte_cnt    <= '0;
      first_blk   <= 1'b1;
      marker_done <= 1'b0;
      len_wr      <= 1'b0;
      final_blk   <= 1'b0;
      tail        <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          len_wr    <= 1'b0;
          final_blk <= 1'b0;
          if (take) begin
            byte_cnt <= byte_cnt + {58'd0, nb};
            widx     <= widx + 4'd1;
            if (in_last) begin
              tail        <= 1'b1;
              marker_done <= (in_nbytes < 3'd4);
            end
          end
        end
        PAD: begin
          widx        <= widx + 4'd1;
          marker_done <= 1'b1;
          if (widx == 4'd14) len_wr <= marker_done;
          if (widx == 4'd15 && len_wr) final_blk <= 1'b1;
        end
        BURST: widx <= widx + 4'd1;
        START: first_blk <= 1'b0;
        DONE: begin
          byte_cnt    <= '0;
          widx        <= '0;
          first_blk   <= 1'b1;
          marker_done <= 1'b0;
          tail        <= 1'b0;
          final_blk   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load         <= 1'b0;
      start        <= 1'b0;
      use_prev_cv  <= 1'b0;
      din          <= '0;
      digest       <= '0;
      digest_valid <= 1'b0;
    end else begin
      load         <= load_d;
      start        <= start_d;
      use_prev_cv  <= upc_d;
      din          <= din_d;
      digest_valid <= (state == DONE);
      if (state == DONE) digest <= core_cv_next;
    end
  end
endmodule
